// File: rtl/conv_window_buffer.sv
// conv_window_buffer: raster pixel stream to 3x3 sliding window via two line buffers.
// Optional window-center coordinates on win_row/win_col under CONV_WINDOW_BUFFER_ROWCOL_EN.
module conv_window_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pushpixel,
  input  logic                pix_valid,
  input  logic [DATA_W-1:0]   pix_data,
  output logic                pix_ready,
  output logic [9*DATA_W-1:0] win_out,
  output logic                win_valid,
  output logic                fin
`ifdef CONV_WINDOW_BUFFER_ROWCOL_EN
  ,
  output logic [RW-1:0]       win_row,
  output logic [CW-1:0]       win_col
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DATA_W-1:0] w [9];
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic accept, last_col, last_row, full;
  assign pix_ready = (state == RUN) && pushpixel;
  assign accept = pix_valid && pix_ready;
  assign last_col = col == CW'(IMG_W - 1);
  assign last_row = row == RW'(IMG_H - 1);
  assign full = row >= RW'(2) && col >= CW'(2);
  assign fin = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      win_valid <= 1'b0;
      for (int k = 0; k < 9; k++) w[k] <= '0;
    end else begin
      win_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          row <= '0;
          col <= '0;
        end
        RUN: if (accept) begin
          col <= last_col ? '0 : col + 1'b1;
          row <= last_col ? row + 1'b1 : row;
          for (int r = 0; r < 3; r++) begin
            w[3*r] <= w[3*r+1];
            w[3*r+1] <= w[3*r+2];
          end
          w[2] <= lb1[col];
          w[5] <= lb0[col];
          w[8] <= pix_data;
          win_valid <= full;
          if (last_col && last_row) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  // Line buffers carry no reset: stale contents are never flagged valid.
  always_ff @(posedge clk)
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_data;
    end
  genvar g;
  for (g = 0; g < 9; g++) begin : g_out
    assign win_out[DATA_W*g +: DATA_W] = w[g];
  end
`ifdef CONV_WINDOW_BUFFER_ROWCOL_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_row <= '0;
      win_col <= '0;
    end else if (state == RUN && accept && full) begin
      win_row <= row - 1'b1;
      win_col <= col - 1'b1;
    end
`endif
endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: randomized frame streaming checked against a positional window model.
module tb_conv_window_buffer;
  localparam int DW = 8, W = 4, H = 3;
  logic clk = 0, rst_n = 0, start = 0, pushpixel = 0, pix_valid = 0;
  logic [DW-1:0] pix_data = '0;
  logic pix_ready, win_valid, fin;
  logic [9*DW-1:0] win_out;
`ifdef CONV_WINDOW_BUFFER_ROWCOL_EN
  logic [1:0] win_row, win_col;
`endif
  int errors = 0, checks = 0;
  logic [DW-1:0] img [W*H];
  always #5 clk = ~clk;
  conv_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pushpixel(pushpixel),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .win_out(win_out), .win_valid(win_valid), .fin(fin)
`ifdef CONV_WINDOW_BUFFER_ROWCOL_EN
    , .win_row(win_row), .win_col(win_col)
`endif
  );
  // Window for the pixel at (r,c): rows r-2..r, cols c-2..c of the frame image.
  function automatic logic [9*DW-1:0] model_win(input int r, input int c);
    logic [9*DW-1:0] m;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        m[DW*(3*rr+cc) +: DW] = img[(r-2+rr)*W + (c-2+cc)];
    return m;
  endfunction
  task automatic start_frame();
    start = 1; pushpixel = 0; pix_valid = 0;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic feed_frame(input bit rnd, input bit gaps, input int base, input int start_at,
                            input int abort_at, output int nv, output int nf);
    int idx, cyc, r, c;
    bit pv, pp, acc, exp_v;
    logic [DW-1:0] d;
    idx = 0; cyc = 0; nv = 0; nf = 0; r = 0; c = 0;
    while (idx < W*H && cyc < 400 && idx != abort_at) begin
      pv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pp = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = rnd ? DW'($urandom) : DW'(base + idx);
      pix_valid = pv; pushpixel = pp; pix_data = d; start = (idx == start_at);
      #1;
      checks++;
      if (pix_ready !== pp) begin errors++; $display("FAIL pix_ready idx=%0d got %b want %b", idx, pix_ready, pp); end
      @(posedge clk); #1;
      cyc++;
      acc = pv && pp;
      exp_v = 0;
      if (acc) begin
        img[idx] = d; r = idx / W; c = idx % W;
        exp_v = r >= 2 && c >= 2;
        idx++;
      end
      checks++;
      if (win_valid !== exp_v) begin errors++; $display("FAIL win_valid idx=%0d got %b want %b", idx, win_valid, exp_v); end
      checks++;
      if (fin !== (acc && idx == W*H)) begin errors++; $display("FAIL fin idx=%0d got %b want %b", idx, fin, acc && idx == W*H); end
      if (win_valid) nv++;
      if (fin) nf++;
      if (exp_v) begin
        checks++;
        if (win_out !== model_win(r, c)) begin errors++; $display("FAIL win_out r=%0d c=%0d got %h want %h", r, c, win_out, model_win(r, c)); end
`ifdef CONV_WINDOW_BUFFER_ROWCOL_EN
        checks++;
        if (win_row !== 2'(r-1) || win_col !== 2'(c-1)) begin
          errors++; $display("FAIL rowcol got (%0d,%0d) want (%0d,%0d)", win_row, win_col, r-1, c-1);
        end
`endif
      end
    end
    start = 0;
    if (cyc >= 400) begin errors++; $display("FAIL frame_timeout idx=%0d got %0d cycles want <400", idx, cyc); end
    if (idx == W*H) begin
      pix_valid = 1; pushpixel = 1;
      #1;
      checks++;
      if (pix_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", pix_ready); end
      @(posedge clk); #1;
      checks++;
      if (win_valid !== 1'b0 || fin !== 1'b0) begin errors++; $display("FAIL idle_pulses got v=%b f=%b want 0 0", win_valid, fin); end
      pix_valid = 0; pushpixel = 0;
    end
  endtask
  task automatic check_counts(input string tag, input int nv, input int nf);
    checks++;
    if (nv !== (W-2)*(H-2) || nf !== 1) begin
      errors++; $display("FAIL %s counts got v=%0d f=%0d want v=%0d f=1", tag, nv, nf, (W-2)*(H-2));
    end
  endtask
  task automatic test_reset();
    rst_n = 0; pushpixel = 1; pix_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (win_out !== '0 || win_valid !== 1'b0 || fin !== 1'b0 || pix_ready !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got %h %b %b %b want all 0", win_out, win_valid, fin, pix_ready);
    end
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (pix_ready !== 1'b0 || win_valid !== 1'b0) begin errors++; $display("FAIL idle_no_accept got r=%b v=%b want 0 0", pix_ready, win_valid); end
    pushpixel = 0; pix_valid = 0;
  endtask
  task automatic test_basic();
    int nv, nf;
    logic [9*DW-1:0] last;
    start_frame();
    feed_frame(0, 0, 1, -1, -1, nv, nf);
    check_counts("basic", nv, nf);
    last = 72'h0c0b0a_080706_040302;
    checks++;
    if (win_out !== last) begin errors++; $display("FAIL basic_last_window got %h want %h", win_out, last); end
  endtask
  task automatic test_gaps();
    int nv, nf;
    for (int i = 0; i < 4; i++) begin
      start_frame();
      feed_frame(i != 0, 1, 1, -1, -1, nv, nf);
      check_counts("gaps", nv, nf);
    end
  endtask
  task automatic test_start_in_run();
    int nv, nf;
    start_frame();
    feed_frame(0, 1, 1, 5, -1, nv, nf);
    check_counts("start_in_run", nv, nf);
  endtask
  task automatic test_abort();
    int nv, nf;
    start_frame();
    feed_frame(0, 0, 1, -1, 7, nv, nf);
    pix_valid = 1; pushpixel = 1;
    rst_n = 0;
    #1;
    checks++;
    if (win_out !== '0 || win_valid !== 1'b0 || fin !== 1'b0 || pix_ready !== 1'b0) begin
      errors++; $display("FAIL abort_reset got %h %b %b %b want all 0", win_out, win_valid, fin, pix_ready);
    end
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (fin !== 1'b0 || win_valid !== 1'b0) begin errors++; $display("FAIL abort_no_fin got f=%b v=%b want 0 0", fin, win_valid); end
    end
    start_frame();
    feed_frame(0, 0, 101, -1, -1, nv, nf);
    check_counts("after_abort", nv, nf);
  endtask
  task automatic test_back_to_back();
    int nv, nf;
    for (int i = 0; i < 3; i++) begin
      start_frame();
      feed_frame(1, i == 1, 0, -1, -1, nv, nf);
      check_counts("back_to_back", nv, nf);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_start_in_run();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_window_buffer.md
CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 8, image width in pixels (>=3).
REQ-003 The block SHALL have parameter IMG_H, default 8, image height in pixels (>=3).
REQ-004 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, begins a new frame when in IDLE.
REQ-007 The block SHALL have port pushpixel, input, 1, advance request from the convolution control FSM.
REQ-008 The block SHALL have port pix_valid, input, 1, upstream pixel present.
REQ-009 The block SHALL have port pix_data, input, DATA_W, raster-order pixel.
REQ-010 The block SHALL have port pix_ready, output, 1, equals pushpixel while in RUN, else 0 (combinational).
REQ-011 The block SHALL have port win_out, output, 9*DATA_W, 3x3 window; slice k=3*r+c at [DATA_W*k +: DATA_W]; r=0 oldest row, c=0 oldest column; k=8 newest pixel.
REQ-012 The block SHALL have port win_valid, output, 1, one-cycle pulse marking a complete new window.
REQ-013 The block SHALL have port fin, output, 1, one-cycle pulse after the frame's last pixel is accepted.

Function
REQ-014 An accept SHALL occur on a rising edge where pix_valid && pix_ready; no other state changes inside RUN otherwise.
REQ-015 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on accept at row=IMG_H-1, col=IMG_W-1; DONE->IDLE unconditionally after one cycle.
REQ-016 start SHALL be ignored in RUN and DONE; on IDLE->RUN, row and col counters SHALL clear to 0.
REQ-017 Per accept, col SHALL increment, wrapping IMG_W-1->0 with row incrementing; counters SHALL be minimal-width unsigned.
REQ-018 Two line buffers of IMG_W entries SHALL be kept: on accept at col, lb1[col]<=lb0[col], lb0[col]<=pix_data (old values read first).
REQ-019 On accept, window columns SHALL shift toward c=0 and new column c=2 SHALL load {r0: old lb1[col], r1: old lb0[col], r2: pix_data}.
REQ-020 win_valid SHALL pulse in the cycle after an accept whose pre-increment row>=2 and col>=2; win_out SHALL then be stable until the next accept.
REQ-021 Window/line-buffer contents from a prior frame SHALL NOT produce win_valid; validity depends only on counters.
REQ-022 fin SHALL be high exactly in the DONE cycle; win_valid for the last pixel SHALL coincide with fin.
REQ-023 pushpixel held high with pix_valid low SHALL stall without counter change; pix_valid high with pushpixel low SHALL not be accepted.
REQ-024 Exactly (IMG_W-2)*(IMG_H-2) win_valid pulses SHALL occur per frame.

Reset
REQ-025 On rst_n low, state SHALL go IDLE, counters 0, win_out 0, win_valid 0, fin 0, immediately and asynchronously.
REQ-026 Reset mid-frame SHALL abandon the frame; no fin SHALL follow; line-buffer contents need not be cleared.
REQ-027 Release of rst_n SHALL be synchronous-deasserted externally; the block requires no cycles to recover.

Configuration
REQ-028 With macro CONV_WINDOW_BUFFER_ROWCOL_EN defined, outputs win_row and win_col (counter widths) SHALL give the window-center coordinates (row-1, col-1 of the newest pixel), registered with win_valid.
REQ-029 Without CONV_WINDOW_BUFFER_ROWCOL_EN, win_row/win_col ports and their logic SHALL be absent; all other behaviour identical.

Verification (IMG_W=4, IMG_H=3, DATA_W=8)
REQ-030 Reset then start, feed pixels 1..12 with pushpixel=pix_valid=1 -> first win_valid after pixel 11, win_out k0..k8 = 1,2,3,5,6,7,9,10,11.
REQ-031 Same frame continued -> second win_valid after pixel 12 with window 2,3,4,6,7,8,10,11,12, fin high same cycle, exactly 2 win_valid total, then IDLE.
REQ-032 Random pix_valid/pushpixel gaps during frame -> identical window sequence and counts to REQ-030/031.
REQ-033 start pulsed in RUN after pixel 5 -> ignored, frame completes normally with one fin.
REQ-034 rst_n low after pixel 7, then new frame 101..112 -> outputs 0 during reset, no fin for aborted frame, windows {101,102,103,105,...,111} and {102,...,112}.
REQ-035 With CONV_WINDOW_BUFFER_ROWCOL_EN -> win_row/win_col = (1,1) then (1,2) alongside the two win_valid pulses.
